temp_alarm_beeper: RTL

TEMP_ALARM_BEEPER -- requirements
Module: temp_alarm_beeper

---
 rtl/temp_alarm_pkg.sv | 20 ++
 rtl/temp_alarm_beeper_tone_gen.sv | 50 +++++
 rtl/temp_alarm_beeper.sv | 102 ++++++++++
 3 files changed

// File: rtl/temp_alarm_pkg.sv
// Shared constants and types for the cold-temperature alarm beeper.
// Counter widths come from the parameter defaults.
package temp_alarm_pkg;

    localparam int LEVEL_W      = 6;
    localparam int CONFIRM_DEF  = 4;
    localparam int TONE_DIV_DEF = 25000;
    localparam int BEEP_CYC_DEF = 5000000;

    localparam int CONF_W  = $clog2(CONFIRM_DEF + 1);
    localparam int TONE_W  = $clog2(TONE_DIV_DEF);
    localparam int PHASE_W = $clog2(BEEP_CYC_DEF);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2
    } beep_state_t;

endpackage

// File: rtl/temp_alarm_beeper_tone_gen.sv
// Square-wave tone generator: half-period TONE_DIV cycles, restartable, with a
// registered, mute-gated output. Mute gates only the output, never the tone phase.
module tone_gen
    import temp_alarm_pkg::*;
#(
    parameter int TONE_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    input  logic mute,
    output logic spk
);

    localparam logic [TONE_W-1:0] DIV_LAST = TONE_W'(TONE_DIV - 1);

    logic [TONE_W-1:0] cnt, cnt_d;
    logic              tone, tone_d;

    always_comb begin
        tone_d = tone;
        cnt_d  = cnt;
        if (!en) begin
            tone_d = 1'b0;
            cnt_d  = '0;
        end else if (restart) begin
            tone_d = 1'b1;
            cnt_d  = '0;
        end else if (cnt == DIV_LAST) begin
            tone_d = ~tone;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tone <= 1'b0;
            spk  <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tone <= tone_d;
            spk  <= tone_d & ~mute;
        end
    end

endmodule

// File: rtl/temp_alarm_beeper.sv
// Debounced cold alarm with a burst-pattern beeper. Optional clear hysteresis is
// enabled by defining TEMP_ALARM_HYST_EN.
module temp_alarm_beeper
    import temp_alarm_pkg::*;
#(
    parameter int THRESH       = 10,
    parameter int CONFIRM      = 4,
    parameter int TONE_DIV     = 25000,
    parameter int BEEP_ON_CYC  = 5000000,
    parameter int BEEP_OFF_CYC = 5000000,
    parameter int HYST         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               level_valid,
    input  logic [LEVEL_W-1:0] level,
    input  logic               mute,
    output logic               alarm,
    output logic               spk,
    output logic               beep_phase
);

    localparam logic [6:0]         THR7      = 7'(THRESH);
    localparam logic [CONF_W-1:0]  CONF_MAX  = CONF_W'(CONFIRM);
    localparam logic [CONF_W-1:0]  CONF_LAST = CONF_W'(CONFIRM - 1);
    localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(BEEP_ON_CYC - 1);
    localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(BEEP_OFF_CYC - 1);

    logic                cold, clr_ok, opposing, toggle, alarm_d, rise, fall;
    logic [CONF_W-1:0]   conf_cnt;
    logic [PHASE_W-1:0]  phase_cnt;
    beep_state_t         state, state_d;

    assign cold = {1'b0, level} < THR7;

`ifdef TEMP_ALARM_HYST_EN
    localparam logic [6:0] CLR_SUM = 7'(THRESH + HYST);
    localparam logic [6:0] CLR_TH  = (CLR_SUM > 7'd63) ? 7'd63 : CLR_SUM;
    assign clr_ok = {1'b0, level} >= CLR_TH;
`else
    logic unused_hyst;
    assign unused_hyst = |7'(HYST);
    assign clr_ok      = !cold;
`endif

    // level_valid is a one-cycle strobe with no backpressure: each high cycle
    // is exactly one sample, low cycles are ignored entirely.
    assign opposing = alarm ? clr_ok : cold;
    assign toggle   = level_valid && opposing && (conf_cnt == CONF_LAST);
    assign alarm_d  = alarm ^ toggle;
    assign rise     = toggle & ~alarm;
    assign fall     = toggle & alarm;

    // Alarm fall wins over any phase-timer expiry in the same cycle.
    always_comb begin
        state_d = state;
        if (fall) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:     if (rise) state_d = BEEP_ON;
                BEEP_ON:  if (phase_cnt == ON_LAST) state_d = BEEP_OFF;
                BEEP_OFF: if (phase_cnt == OFF_LAST) state_d = BEEP_ON;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conf_cnt   <= '0;
            alarm      <= 1'b0;
            state      <= IDLE;
            phase_cnt  <= '0;
            beep_phase <= 1'b0;
        end else begin
            alarm <= alarm_d;
            if (level_valid) begin
                if (toggle || !opposing)
                    conf_cnt <= '0;
                else if (conf_cnt != CONF_MAX)
                    conf_cnt <= conf_cnt + 1'b1;
            end
            state <= state_d;
            if (state_d != state || state_d == IDLE)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 1'b1;
            beep_phase <= (state_d == BEEP_ON);
        end
    end

    tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
        .clk     (clk),
        .rst     (rst),
        .restart ((state_d == BEEP_ON) && (state != BEEP_ON)),
        .en      (state_d == BEEP_ON),
        .mute    (mute),
        .spk     (spk)
    );

endmodule
